relogio_contador: RTL and testbench

//  Time-of-day counter downstream of the adjustment stage. Loads HH:MM:SS in binary

---
 rtl/relogio_contador.sv | 144 ++++++++++++++
 tb/tb_relogio_contador.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relogio_contador.sv
// Time-of-day counter: binary HH:MM:SS with load, per-second prescaler and BCD digit outputs.
// Optional FORMAT_12H_EN shows the hour digits in 12 h form and adds the pm output.
module relogio_contador #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [5:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    output logic [5:0] horas,
    output logic [5:0] minutos,
    output logic [5:0] segundos,
    output logic [3:0] hou_tens,
    output logic [3:0] hou_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
`ifdef FORMAT_12H_EN
    output logic       pm,
`endif
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic [5:0]    horas_nxt_s;
    logic [5:0]    minutos_nxt_s;
    logic [5:0]    segundos_nxt_s;
    logic          sec_pulse_nxt_s;
    logic          day_pulse_nxt_s;
    logic          load_err_nxt_s;
    logic          tick_s;
    logic          load_ok_s;
    logic [5:0]    hour_disp_s;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

    assign tick_s    = run && (presc_r == LAST);
    assign load_ok_s = load && (load_h <= 6'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);

    // Next-state: a valid load overrides the tick; otherwise advance with full carry chain.
    always_comb begin
        presc_nxt_s     = presc_r;
        horas_nxt_s     = horas;
        minutos_nxt_s   = minutos;
        segundos_nxt_s  = segundos;
        sec_pulse_nxt_s = 1'b0;
        day_pulse_nxt_s = 1'b0;
        load_err_nxt_s  = load && !load_ok_s;
        if (load_ok_s) begin
            presc_nxt_s    = '0;
            horas_nxt_s    = load_h;
            minutos_nxt_s  = load_m;
            segundos_nxt_s = load_s;
        end else if (tick_s) begin
            presc_nxt_s     = '0;
            sec_pulse_nxt_s = 1'b1;
            if (segundos == 6'd59) begin
                segundos_nxt_s = 6'd0;
                if (minutos == 6'd59) begin
                    minutos_nxt_s = 6'd0;
                    if (horas == 6'd23) begin
                        horas_nxt_s     = 6'd0;
                        day_pulse_nxt_s = 1'b1;
                    end else begin
                        horas_nxt_s = horas + 6'd1;
                    end
                end else begin
                    minutos_nxt_s = minutos + 6'd1;
                end
            end else begin
                segundos_nxt_s = segundos + 6'd1;
            end
        end else if (run) begin
            presc_nxt_s = presc_r + PW'(1);
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r   <= '0;
            horas     <= 6'd0;
            minutos   <= 6'd0;
            segundos  <= 6'd0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            presc_r   <= presc_nxt_s;
            horas     <= horas_nxt_s;
            minutos   <= minutos_nxt_s;
            segundos  <= segundos_nxt_s;
            sec_pulse <= sec_pulse_nxt_s;
            day_pulse <= day_pulse_nxt_s;
            load_err  <= load_err_nxt_s;
        end
    end

`ifdef FORMAT_12H_EN
    // Midnight shows as 12, afternoon hours fold back to 1..11.
    always_comb begin
        if (horas == 6'd0) begin
            hour_disp_s = 6'd12;
        end else if (horas > 6'd12) begin
            hour_disp_s = horas - 6'd12;
        end else begin
            hour_disp_s = horas;
        end
    end
    assign pm = (horas >= 6'd12);
`else
    assign hour_disp_s = horas;
`endif

    assign hou_tens  = bcd_tens(hour_disp_s);
    assign hou_units = bcd_units(hour_disp_s);
    assign min_tens  = bcd_tens(minutos);
    assign min_units = bcd_units(minutos);
    assign sec_tens  = bcd_tens(segundos);
    assign sec_units = bcd_units(segundos);

endmodule

// File: tb/tb_relogio_contador.sv
// Directed bench for relogio_contador with TICK_CYCLES=4; expected values are hand-computed.
module tb_relogio_contador;

    logic       clk;
    logic       reset;
    logic       run;
    logic       load;
    logic [5:0] load_h;
    logic [5:0] load_m;
    logic [5:0] load_s;
    logic [5:0] horas;
    logic [5:0] minutos;
    logic [5:0] segundos;
    logic [3:0] hou_tens;
    logic [3:0] hou_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       sec_pulse;
    logic       day_pulse;
    logic       load_err;
`ifdef FORMAT_12H_EN
    logic       pm;
`endif

    int tests_run;
    int tests_failed;
    int sec_cnt;
    int day_cnt;
    int err_cnt;

    relogio_contador #(.TICK_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .load      (load),
        .load_h    (load_h),
        .load_m    (load_m),
        .load_s    (load_s),
        .horas     (horas),
        .minutos   (minutos),
        .segundos  (segundos),
        .hou_tens  (hou_tens),
        .hou_units (hou_units),
        .min_tens  (min_tens),
        .min_units (min_units),
        .sec_tens  (sec_tens),
        .sec_units (sec_units),
`ifdef FORMAT_12H_EN
        .pm        (pm),
`endif
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".h"}, 32'(horas), 32'(h));
        check({tag, ".m"}, 32'(minutos), 32'(m));
        check({tag, ".s"}, 32'(segundos), 32'(s));
    endtask

    // One clock edge; outputs sampled 1 time unit later, pulses tallied.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sec_pulse) sec_cnt++;
            if (day_pulse) day_cnt++;
            if (load_err) err_cnt++;
        end
    endtask

    task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        load   = 1'b1;
        load_h = h;
        load_m = m;
        load_s = s;
        step(1);
        load   = 1'b0;
    endtask

    task automatic clear_counts();
        sec_cnt = 0;
        day_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_counts();
        reset  = 1'b1;
        run    = 1'b0;
        load   = 1'b0;
        load_h = 6'd0;
        load_m = 6'd0;
        load_s = 6'd0;
        #22;
        check_time("rst", 0, 0, 0);
        check("rst.sec_pulse", 32'(sec_pulse), 32'd0);
        check("rst.sec_units", 32'(sec_units), 32'd0);
        reset = 1'b0;
        step(1);

        // Basic counting: 12 cycles -> 3 seconds.
        run = 1'b1;
        clear_counts();
        step(12);
        check_time("count12", 0, 0, 3);
        check("count12.pulses", 32'(sec_cnt), 32'd3);
        check("count12.sec_tens", 32'(sec_tens), 32'd0);
        check("count12.sec_units", 32'(sec_units), 32'd3);

        // Day wrap from 23:59:59.
        do_load(6'd23, 6'd59, 6'd59);
        check_time("ld2359", 23, 59, 59);
        check("ld2359.hou_tens", 32'(hou_tens), 32'd2);
        check("ld2359.min_units", 32'(min_units), 32'd9);
        clear_counts();
        step(3);
        check_time("pre_wrap", 23, 59, 59);
        step(1);
        check_time("wrap", 0, 0, 0);
        check("wrap.day_pulse", 32'(day_pulse), 32'd1);
        check("wrap.sec_pulse", 32'(sec_pulse), 32'd1);
        check("wrap.min_tens", 32'(min_tens), 32'd0);
        step(1);
        check("wrap.day_drop", 32'(day_pulse), 32'd0);
        check("wrap.day_cnt", 32'(day_cnt), 32'd1);

        // Rejected loads while frozen.
        run = 1'b0;
        clear_counts();
        do_load(6'd24, 6'd10, 6'd10);
        check("bad_h.load_err", 32'(load_err), 32'd1);
        check_time("bad_h", 0, 0, 0);
        step(1);
        check("bad_h.err_drop", 32'(load_err), 32'd0);
        do_load(6'd10, 6'd60, 6'd10);
        check("bad_m.load_err", 32'(load_err), 32'd1);
        check_time("bad_m", 0, 0, 0);
        check("bad.err_cnt", 32'(err_cnt), 32'd2);

        // Minute-to-hour carry without day pulse.
        run = 1'b1;
        do_load(6'd0, 6'd59, 6'd59);
        clear_counts();
        step(4);
        check_time("carry", 1, 0, 0);
        check("carry.day_cnt", 32'(day_cnt), 32'd0);
        check("carry.sec_pulse", 32'(sec_pulse), 32'd1);

        // Valid load on the tick edge wins; tick is dropped.
        step(3);
        clear_counts();
        do_load(6'd12, 6'd34, 6'd56);
        check_time("ld_tick", 12, 34, 56);
        check("ld_tick.sec_pulse", 32'(sec_pulse), 32'd0);
        step(3);
        check_time("ld_tick+3", 12, 34, 56);
        step(1);
        check_time("ld_tick+4", 12, 34, 57);
        check("ld_tick.sec_cnt", 32'(sec_cnt), 32'd1);

        // Invalid load on the tick edge: tick still happens.
        step(3);
        do_load(6'd24, 6'd0, 6'd0);
        check_time("bad_tick", 12, 34, 58);
        check("bad_tick.load_err", 32'(load_err), 32'd1);
        check("bad_tick.sec_pulse", 32'(sec_pulse), 32'd1);
        check("bad_tick.sec_tens", 32'(sec_tens), 32'd5);
        check("bad_tick.sec_units", 32'(sec_units), 32'd8);

        // Freeze keeps prescaler phase.
        step(2);
        run = 1'b0;
        clear_counts();
        step(20);
        check_time("frozen", 12, 34, 58);
        check("frozen.pulses", 32'(sec_cnt + day_cnt + err_cnt), 32'd0);
        run = 1'b1;
        step(1);
        check("resume1.s", 32'(segundos), 32'd58);
        step(1);
        check("resume2.s", 32'(segundos), 32'd59);
        check("resume2.sec_pulse", 32'(sec_pulse), 32'd1);

`ifdef FORMAT_12H_EN
        run = 1'b0;
        do_load(6'd0, 6'd0, 6'd0);
        check("h12_0.tens", 32'(hou_tens), 32'd1);
        check("h12_0.units", 32'(hou_units), 32'd2);
        check("h12_0.pm", 32'(pm), 32'd0);
        do_load(6'd13, 6'd5, 6'd0);
        check("h12_13.tens", 32'(hou_tens), 32'd0);
        check("h12_13.units", 32'(hou_units), 32'd1);
        check("h12_13.pm", 32'(pm), 32'd1);
        check("h12_13.h", 32'(horas), 32'd13);
        do_load(6'd12, 6'd0, 6'd0);
        check("h12_12.units", 32'(hou_units), 32'd2);
        check("h12_12.pm", 32'(pm), 32'd1);
        run = 1'b1;
`endif

        // Asynchronous reset mid-count, then full period before first tick.
        do_load(6'd5, 6'd6, 6'd7);
        step(2);
        #2;
        reset = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst.min_units", 32'(min_units), 32'd0);
        check("async_rst.sec_pulse", 32'(sec_pulse), 32'd0);
`ifdef FORMAT_12H_EN
        check("async_rst.hou_units", 32'(hou_units), 32'd2);
`else
        check("async_rst.hou_units", 32'(hou_units), 32'd0);
`endif
        step(1);
        reset = 1'b0;
        step(3);
        check("post_rst3.s", 32'(segundos), 32'd0);
        step(1);
        check("post_rst4.s", 32'(segundos), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
